lab3_serial_cla_adder: RTL
==========================

# lab3_serial_cla_adder

Nibble-serial adder that sums two `4*NIBBLES`-bit operands one 4-bit carry-lookahead slice per clock. The carry is held in a register between slices. It is the addition counterpart of the lab's 4-bit borrow-lookahead subtractor and shares its propagate/generate slice structure. It sits behind a start/done handshake so a controller or datapath can trade area for latency on wide additions.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width is `W = 4*NIBBLES` (16 by default). Legal range is 2–8.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `start`  input  1  request a new addition; sampled only in IDLE.
- `X`  input  W  augend; captured on the accepting edge.
- `Y`  input  W  addend; captured on the accepting edge.
- `Cin`  input  1  carry-in; captured on the accepting edge.
- `Sum`  output  W  registered result.
- `Cout`  output  1  registered carry out of bit W-1.
- `V`  output  1  registered signed overflow, defined as carry into the MSB XOR carry out of the MSB.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse while in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `start`=1, capture X, Y and Cin into operand and carry registers, clear the nibble index to 0, and go to RUN.
  - If `start`=0, remain in IDLE.
- RUN, one slice per edge with index k:
  - Per bit: P = X^Y and G = X&Y on nibble k.
  - Lookahead carries are computed from the carry register.
  - The sum nibble is written to the partial-sum register at bits [4k+3:4k].
  - The carry register takes C[4] of the slice.
  - The index increments.
- Leaving RUN: on the edge that processes k = NIBBLES-1:
  - Load `Sum` from the completed partial sum, with nibble k merged in on the same edge.
  - Load `Cout` with C[4] of the slice.
  - Load `V` with C[3]^C[4] of the slice.
  - Go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored and is not queued. Operands changing after capture have no effect.
- `Sum`, `Cout` and `V` hold their last result until the next completion. They do not change during a following RUN.
- Arithmetic is unsigned modulo 2^W, with the carry reported in `Cout`. The widths of X, Y and Sum are exactly W, with no sign extension.
- Reset: when `rst_n`=0 at an edge, regardless of state (including mid-RUN):
  - The state goes to IDLE.
  - `Sum`=0, `Cout`=0, `V`=0, `busy`=0, `done`=0.
  - The partial-sum, carry and index registers are cleared.
  - An aborted operation produces no `done` and no result update.
  - Reset takes priority over `start` on the same edge.

## Timing
- Edge t accepts `start`. Slices are processed at edges t+1 … t+NIBBLES.
- `Sum`, `Cout` and `V` are valid, and `done`=1, during the cycle after edge t+NIBBLES.
- Latency from the start edge to the `done` cycle is NIBBLES cycles (4 by default).
- `busy` rises after edge t and falls after edge t+NIBBLES+1.
- The earliest next accept is at edge t+NIBBLES+2, giving a throughput of one addition per NIBBLES+2 cycles.
- `done` is never high for two consecutive cycles.
- Combinational path per edge: one 4-bit lookahead slice. There is no ripple across slices.

## Structure
- Shared package `lab3_pkg`:
  - State enum IDLE/RUN/DONE.
  - `NIBBLE_W = 4`.
- Sub-module `lab3_cla_nibble`:
  - Combinational 4-bit slice.
  - Inputs: X[3:0], Y[3:0], C0.
  - Outputs: S[3:0], C[4:1] (C[4:1] exposed so the top can form V).
  - Uses G = X&Y, the adder form of the subtractor's G = !X&Y.
  - Must be instantiated exactly once; the top muxes nibble k into it.
- Top module: FSM, operand registers, index counter, carry register, and output registers.

## Test plan
- X=0x1234, Y=0x4321, Cin=0 → `done` 4 cycles after the accepting edge; Sum=0x5555, Cout=0, V=0.
- X=0xFFFF, Y=0x0001, Cin=0 → Sum=0x0000, Cout=1, V=0. This checks carry propagation across all slice boundaries.
- X=0x7FFF, Y=0x0001, Cin=0 → Sum=0x8000, Cout=0, V=1. Also X=0x8000, Y=0x8000 → Sum=0x0000, Cout=1, V=1.
- X=0x0000, Y=0xFFFF, Cin=1 → Sum=0x0000, Cout=1. Then hold `start`=1 continuously: a second operation is accepted exactly 6 cycles after the first, and `start` pulses during RUN/DONE are ignored.
- Start X=0x00FF, Y=0x0001, then drive `rst_n`=0 at the second RUN edge. Required: all outputs are 0 on the next cycle, no `done` appears, and a following X=0x0002, Y=0x0003 yields Sum=0x0005.
- Randomized 1000 operations against a W-bit reference model at NIBBLES=4 and NIBBLES=2. Check Sum, Cout and V, and that `done` appears exactly once per accept.

Source files
------------

// File: rtl/lab3_serial_cla_adder_pkg.sv
// Shared types for the lab3 nibble-serial adder: FSM state encoding and slice width.
package lab3_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lab3_serial_cla_adder_if.sv
// Start/done handshake bundle between a controller (master) and the serial adder (slave).
interface lab3_serial_cla_adder_if #(
    parameter int NIBBLES = 4
);
    import lab3_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Cin;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         V;
    logic         busy;
    logic         done;

    modport master (
        output start, X, Y, Cin,
        input  Sum, Cout, V, busy, done
    );

    modport slave (
        input  start, X, Y, Cin,
        output Sum, Cout, V, busy, done
    );

endinterface

// File: rtl/lab3_serial_cla_adder_cla_nibble.sv
// Combinational 4-bit carry-lookahead slice; all carries flattened from C0 (no ripple).
module lab3_cla_nibble (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c0,
    output logic [3:0] s,
    output logic [4:1] c
);
    logic [3:0] p;
    logic [3:0] g;

    assign p = x ^ y;
    assign g = x & y;

    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c[3:1], c0};

endmodule

// File: rtl/lab3_serial_cla_adder.sv
// Nibble-serial adder: one shared lookahead slice walks the operands LSB-first, carry held in a register.
module lab3_serial_cla_adder
    import lab3_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lab3_serial_cla_adder_if.slave  bus
);
    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    x_q, y_q, psum_q, psum_d;
    logic            c_q;

    logic [3:0]      x_nib, y_nib, s_nib;
    logic [4:1]      c_nib;
    logic            last;
    logic            unused_c;

    // Only one slice exists; the index selects which nibble feeds it this cycle.
    assign x_nib = x_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign y_nib = y_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign last  = (idx_q == LAST);

    lab3_cla_nibble u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .c0 (c_q),
        .s  (s_nib),
        .c  (c_nib)
    );

    assign unused_c = ^c_nib[2:1];

    always_comb begin
        state_d = state_q;
        psum_d  = psum_q;
        psum_d[{idx_q, 2'b00} +: NIBBLE_W] = s_nib;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= 1'b0;
            psum_q   <= '0;
            bus.Sum  <= '0;
            bus.Cout <= 1'b0;
            bus.V    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q    <= bus.X;
                        y_q    <= bus.Y;
                        c_q    <= bus.Cin;
                        idx_q  <= '0;
                        psum_q <= '0;
                    end
                end
                RUN: begin
                    psum_q <= psum_d;
                    c_q    <= c_nib[4];
                    idx_q  <= idx_q + 1'b1;
                    // Outputs only move on completion, so they hold through the next RUN.
                    if (last) begin
                        bus.Sum  <= psum_d;
                        bus.Cout <= c_nib[4];
                        bus.V    <= c_nib[4] ^ c_nib[3];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q == RUN) || (state_q == DONE);
    assign bus.done = (state_q == DONE);

endmodule
